// File: rtl/accel_spi_reader.sv
// Periodic SPI mode-3 master reading one 16-bit accelerometer sample per SAMPLE_PERIOD.
// Optional feature macro: ACCEL_OFFSET_EN (subtract OFFSET with saturation).
module accel_spi_reader #(
  parameter int unsigned        STATE_BITS    = 16,
  parameter int unsigned        CLK_DIV       = 4,
  parameter int unsigned        SAMPLE_PERIOD = 1000,
  parameter logic [5:0]         REG_ADDR      = 6'h32,
  parameter logic signed [15:0] OFFSET        = 16'sh0000
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         spi_cs_n,
  output logic                         spi_sclk,
  output logic                         spi_mosi,
  input  logic                         spi_miso,
  output logic signed [STATE_BITS-1:0] z_out,
  output logic                         z_valid,
  output logic                         busy
);

  localparam int unsigned TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [DW-1:0]           div_q, div_d;
  logic [5:0]              half_q, half_d;
  logic [7:0]              cmd_q, cmd_d;
  logic [15:0]             rx_q, rx_d;
  logic                    cs_n_q, cs_n_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic [STATE_BITS-1:0]   z_q, z_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;

  logic [5:0]              half_nxt;
  logic [15:0]             raw;
  logic [STATE_BITS-1:0]   sample;

  // Low byte arrives first, so it sits in the upper half of the shift register.
  assign raw = {rx_q[7:0], rx_q[15:8]};

`ifdef ACCEL_OFFSET_EN
  logic [16:0] diff;
  always_comb begin
    diff = {raw[15], raw} - {OFFSET[15], OFFSET};
    if (diff[16] != diff[15]) begin
      sample = diff[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      sample = diff[15:0];
    end
  end
`else
  logic unused_offset;
  assign unused_offset = ^OFFSET;
  assign sample        = raw;
`endif

  // half_q counts SCLK half-periods since CS fell: odd indices are falling
  // edges (MOSI update), even indices 2..48 are rising edges (MISO sample).
  always_comb begin
    state_d  = state_q;
    timer_d  = (timer_q == T_LAST) ? '0 : timer_q + 1'b1;
    div_d    = div_q;
    half_d   = half_q;
    cmd_d    = cmd_q;
    rx_d     = rx_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    z_d      = z_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    half_nxt = half_q + 6'd1;

    case (state_q)
      IDLE: begin
        if (timer_q == T_LAST) begin
          state_d = SHIFT;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          half_d  = '0;
          cmd_d   = {2'b11, REG_ADDR};
        end
      end
      SHIFT, HOLD: begin
        if (div_q == D_LAST) begin
          div_d  = '0;
          half_d = half_nxt;
          if (half_nxt <= 6'd48) begin
            if (!half_q[0]) begin
              sclk_d = 1'b0;
              mosi_d = (half_q < 6'd16) ? cmd_q[7] : 1'b0;
              cmd_d  = {cmd_q[6:0], 1'b0};
            end else begin
              sclk_d = 1'b1;
              if (half_q >= 6'd17) begin
                rx_d = {rx_q[14:0], spi_miso};
              end
            end
          end
          if (half_nxt == 6'd49) begin
            state_d = HOLD;
          end
          if (half_nxt == 6'd50) begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            z_d     = sample;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      div_q   <= '0;
      half_q  <= '0;
      cmd_q   <= '0;
      rx_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      z_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      half_q  <= half_d;
      cmd_q   <= cmd_d;
      rx_q    <= rx_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      z_q     <= z_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign z_out    = z_q;
  assign z_valid  = valid_q;
  assign busy     = busy_q;

endmodule
